// File: rtl/fifo_pkg.sv
// Shared sizing for the register-entry FIFO: default geometry and the
// pointer/occupancy width derivations used by every instance.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy must represent DEPTH itself, hence one extra code point.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);
  localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/reg_n.sv
// WIDTH-bit storage register with write enable; clears to zero on reset.
module reg_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/reg_fifo.sv
// First-word-fall-through FIFO of DEPTH register entries with occupancy
// count and a sticky overflow/underflow flag.
module reg_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         pop,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [WIDTH-1:0] entries [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot at full, so a same-cycle push may take it.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  genvar i;
  for (i = 0; i < DEPTH; i++) begin : g_entry
    reg_n #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push_ok && (wp == PTR_W'(i))),
      .d     (data_in),
      .q     (entries[i])
    );
  end

  assign data_out = entries[rp];

  // DEPTH is a power of two, so pointer increments wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if ((pop && empty) || (push && full && !pop)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_fifo.sv
// Directed bench for reg_fifo (WIDTH=16, DEPTH=8) with hand-computed expectations.
module tb_reg_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             err;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] d;

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .data_in  (data_in),
    .pop      (pop),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present inputs, take one rising edge, sample 1 ns later with inputs idle.
  task automatic cyc(input logic ps, input logic pp, input logic [WIDTH-1:0] dv);
    push    = ps;
    pop     = pp;
    data_in = dv;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_dout",  32'(data_out), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill 1..8; first word must appear the cycle after its push.
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, WIDTH'(k));
      if (k == 1) chk("latency_dout", 32'(data_out), 32'h1);
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_head",  32'(data_out), 32'h1);

    // Push with pop at full: head leaves, 0x0009 takes the freed slot.
    cyc(1'b1, 1'b1, 16'h0009);
    chk("sim_count", 32'(count), 32'd8);
    chk("sim_head",  32'(data_out), 32'h2);
    chk("sim_err",   32'(err), 32'd0);

    // Overflow: rejected push, sticky error.
    cyc(1'b1, 1'b0, 16'h00FF);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_err",   32'(err), 32'd1);
    chk("ovf_head",  32'(data_out), 32'h2);
    cyc(1'b0, 1'b0, '0);
    chk("ovf_err_sticky", 32'(err), 32'd1);

    // Drain: expect 2..9, 0x00FF never stored.
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("drain_%0d", k), 32'(data_out), 32'(k));
      cyc(1'b0, 1'b1, '0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // Underflow on a fresh FIFO.
    do_reset();
    chk("reset_clears_err", 32'(err), 32'd0);
    cyc(1'b0, 1'b1, '0);
    chk("udf_count", 32'(count), 32'd0);
    chk("udf_empty", 32'(empty), 32'd1);
    chk("udf_err",   32'(err), 32'd1);
    cyc(1'b1, 1'b0, 16'h00AB);
    chk("udf_rp_kept", 32'(data_out), 32'hAB);
    chk("udf_push_cnt", 32'(count), 32'd1);

    // Push with pop on empty: push taken, pop ignored, still flagged.
    do_reset();
    cyc(1'b1, 1'b1, 16'h0C0C);
    chk("emp_pp_count", 32'(count), 32'd1);
    chk("emp_pp_dout",  32'(data_out), 32'h0C0C);
    chk("emp_pp_err",   32'(err), 32'd1);

    // Wrap: hold occupancy at 3 through 20 concurrent push/pop cycles.
    do_reset();
    q.delete();
    for (int k = 0; k < 3; k++) begin
      d = 16'h0100 + WIDTH'(k);
      cyc(1'b1, 1'b0, d);
      q.push_back(d);
    end
    for (int k = 0; k < 20; k++) begin
      d = 16'h0200 + WIDTH'(k);
      cyc(1'b1, 1'b1, d);
      q.push_back(d);
      void'(q.pop_front());
      chk($sformatf("wrap_dout_%0d", k), 32'(data_out), 32'(q[0]));
      chk($sformatf("wrap_cnt_%0d", k),  32'(count), 32'd3);
    end
    chk("wrap_err", 32'(err), 32'd0);

    // Asynchronous reset mid-stream at count 5, away from any clock edge.
    cyc(1'b1, 1'b0, 16'h0300);
    cyc(1'b1, 1'b0, 16'h0301);
    chk("pre_rst_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full),  32'd0);
    chk("arst_err",   32'(err),   32'd0);
    chk("arst_dout",  32'(data_out), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
